// File: rtl/gpp_tx_link_sender.sv
// gpp_tx_link_sender: buffers GPP words and sends them as a header-framed packet of flits.
module gpp_tx_link_sender #(
  parameter int DEPTH  = 8,
  parameter int LINK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       gpp_tx_data,
  input  logic              gpp_trf_dp,
  input  logic              gpp_commit,
  output logic              gpp_trf_cp,
  output logic              tx_overflow,
  output logic [7:0]        tx_count,
  output logic              tx_valid,
  output logic [LINK_W-1:0] tx_data,
  input  logic              tx_ready
);
  localparam int F  = 16 / LINK_W;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = F > 1 ? $clog2(F) : 1;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
  state_t state, state_n;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fidx;
  logic [15:0] sh, nxt_word;
  logic [7:0] n_words;
  logic acc, last_flit, push_ok, commit_ok, pop;
  always_comb begin
    acc       = tx_valid && tx_ready;
    last_flit = acc && fidx == FW'(F - 1);
    push_ok   = gpp_trf_dp && state == IDLE && tx_count != 8'(DEPTH);
    n_words   = tx_count + 8'(push_ok);
    commit_ok = gpp_commit && state == IDLE && n_words != 8'd0;
    pop       = last_flit && state == PAYLOAD;
    state_n   = commit_ok                          ? HEADER  :
                (last_flit && state == HEADER)     ? PAYLOAD :
                (pop && tx_count == 8'd1)          ? IDLE    : state;
    // The word after the header is the FIFO head; later words sit one past the word being popped.
    nxt_word  = state_n == IDLE  ? 16'd0 :
                commit_ok        ? {8'hA5, n_words} :
                state == HEADER  ? mem[rd_ptr] : mem[rd_ptr + 1'b1];
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= gpp_tx_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_count    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      gpp_trf_cp  <= 1'b1;
      tx_overflow <= 1'b0;
      fidx        <= '0;
      sh          <= '0;
    end else begin
      state       <= state_n;
      gpp_trf_cp  <= state_n == IDLE;
      wr_ptr      <= wr_ptr + AW'(push_ok);
      rd_ptr      <= rd_ptr + AW'(pop);
      tx_count    <= tx_count + 8'(push_ok) - 8'(pop);
      tx_overflow <= (tx_overflow && !commit_ok) || (gpp_trf_dp && !push_ok);
      if (commit_ok || last_flit) begin
        tx_valid <= state_n != IDLE;
        tx_data  <= nxt_word[15 -: LINK_W];
        sh       <= nxt_word << LINK_W;
        fidx     <= '0;
      end else if (acc) begin
        tx_data  <= sh[15 -: LINK_W];
        sh       <= sh << LINK_W;
        fidx     <= fidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gpp_tx_link_sender.sv
// tb_gpp_tx_link_sender: directed scoreboard bench for gpp_tx_link_sender (LINK_W=4, DEPTH=8).
module tb_gpp_tx_link_sender;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] gpp_tx_data = '0;
  logic        gpp_trf_dp = 1'b0;
  logic        gpp_commit = 1'b0;
  logic        gpp_trf_cp, tx_overflow, tx_valid;
  logic [7:0]  tx_count;
  logic [3:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [3:0]  exp_q [$];
  logic [15:0] mdl [$];
  logic        m_busy = 1'b0;
  logic        prev_stall = 1'b0;
  logic [3:0]  prev_data = '0;
  time         t_commit;
  int          vecs = 0, errs = 0, cyc;

  gpp_tx_link_sender #(.DEPTH(8), .LINK_W(4)) dut (
    .clk(clk), .rst(rst), .gpp_tx_data(gpp_tx_data), .gpp_trf_dp(gpp_trf_dp),
    .gpp_commit(gpp_commit), .gpp_trf_cp(gpp_trf_cp), .tx_overflow(tx_overflow),
    .tx_count(tx_count), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 16'(tx_valid), 16'd1);
        chk("hold_data", 16'(tx_data), 16'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        vecs++;
        assert (exp_q.size() > 0) else begin
          errs++;
          $error("FAIL extra_flit: observed %h expected none", tx_data);
        end
        if (exp_q.size() > 0) chk("flit", 16'(tx_data), 16'(exp_q.pop_front()));
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    gpp_tx_data = w;
    gpp_trf_dp  = 1'b1;
    if (!m_busy && mdl.size() < 8) mdl.push_back(w);
    step();
    gpp_trf_dp = 1'b0;
  endtask

  task automatic enq_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*4 +: 4]);
  endtask

  task automatic commit(input logic with_push, input logic [15:0] w);
    gpp_commit = 1'b1;
    if (with_push) begin
      gpp_tx_data = w;
      gpp_trf_dp  = 1'b1;
      if (!m_busy && mdl.size() < 8) mdl.push_back(w);
    end
    if (!m_busy && mdl.size() > 0) begin
      enq_word({8'hA5, 8'(mdl.size())});
      while (mdl.size() > 0) enq_word(mdl.pop_front());
      m_busy = 1'b1;
    end
    step();
    gpp_commit = 1'b0;
    gpp_trf_dp = 1'b0;
    t_commit   = $time;
  endtask

  task automatic wait_idle(input string tag, input int exp_cyc);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      if (gpp_trf_cp && exp_q.size() == 0) done = 1'b1;
      else begin
        step();
        n++;
      end
    end
    vecs++;
    assert (done) else begin
      errs++;
      $error("FAIL %s_timeout: observed busy after %0d cycles expected idle", tag, n);
    end
    cyc = int'(($time - t_commit) / 10);
    chk({tag, "_cycles"}, 16'(cyc), 16'(exp_cyc));
    chk({tag, "_count"}, 16'(tx_count), 16'd0);
    m_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_cp", 16'(gpp_trf_cp), 16'd1);
    chk("rst_valid", 16'(tx_valid), 16'd0);
    chk("rst_count", 16'(tx_count), 16'd0);
    chk("rst_ovf", 16'(tx_overflow), 16'd0);
    chk("rst_data", 16'(tx_data), 16'd0);
    rst = 1'b0;
    step();

    push(16'h1234);
    chk("basic_count1", 16'(tx_count), 16'd1);
    push(16'hABCD);
    chk("basic_count2", 16'(tx_count), 16'd2);
    commit(1'b0, 16'h0);
    chk("basic_cp_low", 16'(gpp_trf_cp), 16'd0);
    chk("basic_first_valid", 16'(tx_valid), 16'd1);
    chk("basic_first_flit", 16'(tx_data), 16'hA);
    wait_idle("basic", 12);
    chk("basic_valid_after", 16'(tx_valid), 16'd0);

    push(16'h1234);
    push(16'hABCD);
    commit(1'b0, 16'h0);
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold5", 16'(tx_data), 16'h5);
      step();
    end
    tx_ready = 1'b1;
    wait_idle("bp", 15);

    for (int i = 1; i <= 9; i++) push(16'(i));
    chk("full_count", 16'(tx_count), 16'd8);
    chk("full_ovf", 16'(tx_overflow), 16'd1);
    commit(1'b0, 16'h0);
    chk("full_ovf_clr", 16'(tx_overflow), 16'd0);
    wait_idle("full", 36);

    push(16'h1111);
    commit(1'b1, 16'h2222);
    chk("simul_hdr_flit", 16'(tx_data), 16'hA);
    repeat (4) step();
    push(16'h3333);
    chk("payload_push_ovf", 16'(tx_overflow), 16'd1);
    chk("payload_push_count", 16'(tx_count), 16'd2);
    wait_idle("simul", 12);
    chk("simul_ovf_sticky", 16'(tx_overflow), 16'd1);

    push(16'h0A0A);
    push(16'h0B0B);
    push(16'h0C0C);
    commit(1'b0, 16'h0);
    repeat (5) step();
    chk("mid_count", 16'(tx_count), 16'd3);
    rst = 1'b1;
    exp_q.delete();
    mdl.delete();
    m_busy = 1'b0;
    step();
    chk("midrst_valid", 16'(tx_valid), 16'd0);
    chk("midrst_count", 16'(tx_count), 16'd0);
    chk("midrst_cp", 16'(gpp_trf_cp), 16'd1);
    rst = 1'b0;
    step();
    commit(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("empty_commit_cp", 16'(gpp_trf_cp), 16'd1);
      chk("empty_commit_valid", 16'(tx_valid), 16'd0);
      step();
    end
    chk("final_queue", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gpp_tx_link_sender.md
# gpp_tx_link_sender

Communications-processor block that receives the general-purpose processor's outgoing words, buffers them, and sends them onto the interconnect link. It sits at the far end of the GPP's `gpp_tx_data` / `gpp_trf_dp` path. It returns completion status to the GPP on `gpp_trf_cp`, which the GPP samples through ALU source-1 select 1. Words are framed into a packet and serialized into narrow flits with a valid/ready handshake.

## Interface
- `DEPTH`, 8: word FIFO depth; power of 2, 2..128.
- `LINK_W`, 4: flit width in bits; must divide 16 (1, 2, 4, 8 or 16).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `gpp_tx_data`  in  16  word driven by the GPP.
- `gpp_trf_dp`  in  1  one-cycle push strobe from GPP control.
- `gpp_commit`  in  1  one-cycle strobe to send the buffered words as one packet.
- `gpp_trf_cp`  out  1  1 = idle; the previous packet is fully sent and new words are accepted.
- `tx_overflow`  out  1  sticky; set when a push is dropped.
- `tx_count`  out  8  number of words currently buffered.
- `tx_valid`  out  1  flit valid toward the link.
- `tx_data`  out  LINK_W  flit payload.
- `tx_ready`  in  1  link accepts the flit this cycle.

## Operation
- Flits per word: F = 16/LINK_W. Each word is sent MSB flit first.
- Packet format:
  - Header word {8'hA5, N[7:0]}, where N is the word count latched at commit.
  - Then N payload words, in FIFO order.
- States and transitions:
  - IDLE -> HEADER: on `gpp_commit` with the effective count ≥ 1. A commit with count 0 is ignored.
  - HEADER -> PAYLOAD: after F flits are accepted.
  - PAYLOAD -> IDLE: after N·F flits are accepted; each word is popped as its last flit is accepted.
- Push rules:
  - Accepted only when state is IDLE and the FIFO is not full.
  - A push when full, or in any state other than IDLE, is dropped and sets `tx_overflow`.
  - `tx_overflow` clears only on `rst` or on an accepted commit.
- Simultaneous push and commit in IDLE: the word is accepted and included in the packet, so N = old count + 1.
- A commit outside IDLE is ignored.
- Flit handshake:
  - A flit transfers on `tx_valid && tx_ready`.
  - While `tx_valid=1 && tx_ready=0`, `tx_data` and `tx_valid` hold stable.
  - `tx_valid` never deasserts before acceptance.
- `tx_count` rules:
  - Increments on an accepted push and decrements on a pop.
  - Reaches DEPTH when full.
  - FIFO pointers wrap modulo DEPTH.
- `gpp_trf_cp` = (state == IDLE). It is registered.

## Timing
- All outputs are registered.
- Reset values: `gpp_trf_cp`=1, `tx_valid`=0, `tx_data`=0, `tx_overflow`=0, `tx_count`=0; state IDLE; FIFO empty.
- A reset mid-packet aborts immediately: the next cycle shows the reset values, and buffered words are discarded.
- Push at edge k: `tx_count` updates at k+1.
- Commit at edge k:
  - `gpp_trf_cp`=0 and `tx_valid`=1 with the first header flit at k+1.
  - `tx_overflow` is cleared at k+1.
- Flit accepted at edge j: the next flit, if any, is presented at j+1. There are no bubbles when `tx_ready` is held high.
- With `tx_ready`=1 constantly, the packet occupies (N+1)·F cycles.
- At the edge that accepts the last flit, `tx_valid` falls to 0 and `gpp_trf_cp` rises to 1 for the next cycle.
- Latency from a commit strobe to the first flit is 1 cycle.

## Test plan
All scenarios use LINK_W=4 and DEPTH=8.
- **Reset:** assert `rst` 2 cycles -> `gpp_trf_cp`=1, `tx_valid`=0, `tx_count`=0, `tx_overflow`=0.
- **Basic packet:** push 16'h1234, 16'hABCD; commit; `tx_ready`=1 -> flits A,5,0,2,1,2,3,4,A,B,C,D on 12 consecutive cycles. `gpp_trf_cp` returns to 1 the cycle after the flit D, and `tx_count`=0.
- **Backpressure:** as basic packet, but `tx_ready`=0 for 3 cycles on the second flit -> `tx_data`=5 held stable for 3 cycles; the sequence is otherwise unchanged and takes 15 cycles total.
- **Full and overflow:** push 9 words 16'h0001..16'h0009 -> `tx_count`=8, `tx_overflow`=1. Commit -> header 16'hA508; payload 0001..0008; `tx_overflow` cleared the cycle after the commit.
- **Push during send plus simultaneous push/commit:**
  - Push one word, then push and commit in the same cycle -> header 16'hA502.
  - A push during PAYLOAD is dropped: `tx_overflow`=1, and `tx_count` reaches 0 at the end of the packet.
- **Reset mid-packet and empty commit:**
  - Reset during PAYLOAD with 3 words buffered -> next cycle `tx_valid`=0, `tx_count`=0.
  - A commit with count 0 -> `gpp_trf_cp` stays 1 and no flits are sent.
